// File: rtl/mem_cmd_arbiter.sv
// Two-requester arbiter in front of a single-port memory command/response bus.
// One command in flight at a time; read responses are routed back to the owner.
module mem_cmd_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        m0_cmd_valid,
  output logic        m0_cmd_ready,
  input  logic        m0_cmd_wr,
  input  logic [31:0] m0_cmd_addr,
  input  logic [31:0] m0_cmd_wdata,
  input  logic [3:0]  m0_cmd_be,
  output logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  input  logic        m1_cmd_valid,
  output logic        m1_cmd_ready,
  input  logic        m1_cmd_wr,
  input  logic [31:0] m1_cmd_addr,
  input  logic [31:0] m1_cmd_wdata,
  input  logic [3:0]  m1_cmd_be,
  output logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        s_cmd_valid,
  input  logic        s_cmd_ready,
  output logic        s_cmd_wr,
  output logic [31:0] s_cmd_addr,
  output logic [31:0] s_cmd_wdata,
  output logic [3:0]  s_cmd_be,
  input  logic        s_rsp_ready,
  input  logic [31:0] s_rsp_rdata,
  output logic        grant_id,
  output logic        busy,
  output logic        spurious_rsp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CMD     = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       last_grant_reg;
  logic       winner;
  logic       granted_valid;
  logic       granted_wr;
  logic       in_cmd;
  logic       handshake;

  // Round-robin favours whoever did not complete the most recent handshake.
  always_comb begin
    winner = 1'b0;
    if (m0_cmd_valid && m1_cmd_valid) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_reg;
    end else if (m1_cmd_valid) begin
      winner = 1'b1;
    end
  end

  assign granted_valid = grant_id ? m1_cmd_valid : m0_cmd_valid;
  assign granted_wr    = grant_id ? m1_cmd_wr    : m0_cmd_wr;
  assign in_cmd        = (state_reg == CMD);
  assign handshake     = in_cmd && granted_valid && s_cmd_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (m0_cmd_valid || m1_cmd_valid) state_next = CMD;
      end
      CMD: begin
        if (!granted_valid)   state_next = IDLE;
        else if (s_cmd_ready) state_next = granted_wr ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (s_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_reg      <= IDLE;
      grant_id       <= 1'b0;
      last_grant_reg <= 1'b1;
      spurious_rsp   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (m0_cmd_valid || m1_cmd_valid)) grant_id <= winner;
      if (handshake) last_grant_reg <= grant_id;
      // A response with no read outstanding is dropped and latched as an error.
      if (s_rsp_ready && state_reg != RD_WAIT) spurious_rsp <= 1'b1;
    end
  end

  assign s_cmd_valid  = in_cmd && granted_valid;
  assign s_cmd_wr     = granted_wr;
  assign s_cmd_addr   = grant_id ? m1_cmd_addr  : m0_cmd_addr;
  assign s_cmd_wdata  = grant_id ? m1_cmd_wdata : m0_cmd_wdata;
  assign s_cmd_be     = grant_id ? m1_cmd_be    : m0_cmd_be;
  assign m0_cmd_ready = in_cmd && !grant_id && s_cmd_ready;
  assign m1_cmd_ready = in_cmd &&  grant_id && s_cmd_ready;

  assign m0_rsp_ready = (state_reg == RD_WAIT) && !grant_id && s_rsp_ready;
  assign m1_rsp_ready = (state_reg == RD_WAIT) &&  grant_id && s_rsp_ready;
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter: a round-robin and a fixed-priority
// instance share all inputs; each scenario task checks its own expectations.
module tb_mem_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_;
  logic        m0_cmd_valid, m0_cmd_wr, m1_cmd_valid, m1_cmd_wr;
  logic [31:0] m0_cmd_addr, m0_cmd_wdata, m1_cmd_addr, m1_cmd_wdata;
  logic [3:0]  m0_cmd_be, m1_cmd_be;
  logic        s_cmd_ready, s_rsp_ready;
  logic [31:0] s_rsp_rdata;

  logic        m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        s_cmd_valid, s_cmd_wr, grant_id, busy, spurious_rsp;
  logic [31:0] s_cmd_addr, s_cmd_wdata;
  logic [3:0]  s_cmd_be;

  logic        f_m0_cmd_ready, f_m1_cmd_ready, f_m0_rsp_ready, f_m1_rsp_ready;
  logic [31:0] f_m0_rsp_rdata, f_m1_rsp_rdata;
  logic        f_s_cmd_valid, f_s_cmd_wr, f_grant_id, f_busy, f_spurious_rsp;
  logic [31:0] f_s_cmd_addr, f_s_cmd_wdata;
  logic [3:0]  f_s_cmd_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_cmd_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset_(reset_),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_be(m0_cmd_be),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_be(m1_cmd_be),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
    .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_be(s_cmd_be),
    .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
    .grant_id(grant_id), .busy(busy), .spurious_rsp(spurious_rsp)
  );

  mem_cmd_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset_(reset_),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(f_m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_be(m0_cmd_be),
    .m0_rsp_ready(f_m0_rsp_ready), .m0_rsp_rdata(f_m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(f_m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_be(m1_cmd_be),
    .m1_rsp_ready(f_m1_rsp_ready), .m1_rsp_rdata(f_m1_rsp_rdata),
    .s_cmd_valid(f_s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(f_s_cmd_wr),
    .s_cmd_addr(f_s_cmd_addr), .s_cmd_wdata(f_s_cmd_wdata), .s_cmd_be(f_s_cmd_be),
    .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
    .grant_id(f_grant_id), .busy(f_busy), .spurious_rsp(f_spurious_rsp)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cmd_valid = 0; m0_cmd_wr = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_be = 0;
    m1_cmd_valid = 0; m1_cmd_wr = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_be = 0;
    s_cmd_ready = 0; s_rsp_ready = 0; s_rsp_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_ = 0;
    cyc();
    cyc();
    reset_ = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    m0_cmd_valid = 1; m1_cmd_valid = 1; s_cmd_ready = 1; s_rsp_ready = 1;
    reset_ = 0;
    #1;
    checks++;
    if ({busy, grant_id, s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready, spurious_rsp} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b",
               {busy, grant_id, s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready, spurious_rsp}, 8'b0);
    end
    clear_inputs();
    reset_ = 1;
    cyc();
    checks++;
    if ({busy, spurious_rsp, f_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got %b exp 000", {busy, spurious_rsp, f_busy});
    end
    $display("txn reset done");
  endtask

  task automatic test_read();
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 0; m0_cmd_addr = 32'h100; s_cmd_ready = 1;
    cyc();
    checks++;
    if ({grant_id, s_cmd_valid, s_cmd_wr, m0_cmd_ready, m1_cmd_ready, busy} !== 6'b010101 || s_cmd_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_cmd got %b addr %h exp 010101 addr 00000100",
               {grant_id, s_cmd_valid, s_cmd_wr, m0_cmd_ready, m1_cmd_ready, busy}, s_cmd_addr);
    end
    cyc();
    m0_cmd_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({busy, s_cmd_valid, m0_rsp_ready, m1_rsp_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL read_wait%0d got %b exp 1000", i, {busy, s_cmd_valid, m0_rsp_ready, m1_rsp_ready});
      end
      cyc();
    end
    s_rsp_ready = 1; s_rsp_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_rsp_ready, m1_rsp_ready} !== 2'b10 || m0_rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_rsp got %b data %h exp 10 data deadbeef", {m0_rsp_ready, m1_rsp_ready}, m0_rsp_rdata);
    end
    cyc();
    s_rsp_ready = 0;
    #1;
    checks++;
    if ({busy, m0_rsp_ready, spurious_rsp} !== 3'b000) begin
      errors++;
      $display("FAIL read_done got %b exp 000", {busy, m0_rsp_ready, spurious_rsp});
    end
    $display("txn m0 read 0x100 -> %h", m0_rsp_rdata);
  endtask

  task automatic test_round_robin();
    logic       g;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 1; m0_cmd_addr = 32'h10; m0_cmd_wdata = 32'hA0A0A0A0; m0_cmd_be = 4'h3;
    m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h20; m1_cmd_wdata = 32'hB1B1B1B1; m1_cmd_be = 4'hC;
    s_cmd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      g  = (k % 2 == 1);
      ea = g ? 32'h20 : 32'h10;
      ed = g ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
      eb = g ? 4'hC : 4'h3;
      cyc();
      checks++;
      if (grant_id !== g || s_cmd_valid !== 1'b1 || s_cmd_addr !== ea || s_cmd_wdata !== ed || s_cmd_be !== eb
          || {m1_cmd_ready, m0_cmd_ready} !== {g, ~g}) begin
        errors++;
        $display("FAIL rr_grant%0d got g=%b a=%h d=%h be=%h rdy=%b exp g=%b a=%h d=%h be=%h",
                 k, grant_id, s_cmd_addr, s_cmd_wdata, s_cmd_be, {m1_cmd_ready, m0_cmd_ready}, g, ea, ed, eb);
      end
      $display("txn rr write grant=%0d addr=%h", grant_id, s_cmd_addr);
      cyc();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_gap%0d got busy=%b exp 0", k, busy);
      end
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 1; m0_cmd_addr = 32'h30;
    m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h34;
    s_cmd_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (f_grant_id !== 1'b0 || f_s_cmd_addr !== 32'h30 || f_m1_cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL fp_grant%0d got g=%b a=%h r1=%b exp g=0 a=00000030 r1=0", k, f_grant_id, f_s_cmd_addr, f_m1_cmd_ready);
      end
      $display("txn fp write grant=%0d", f_grant_id);
      cyc();
    end
    m0_cmd_valid = 0;
    cyc();
    checks++;
    if (f_grant_id !== 1'b1 || f_s_cmd_addr !== 32'h34 || f_m1_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fp_m1_alone got g=%b a=%h r1=%b exp g=1 a=00000034 r1=1", f_grant_id, f_s_cmd_addr, f_m1_cmd_ready);
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_stall();
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 1; m0_cmd_addr = 32'h40; s_cmd_ready = 0;
    cyc();
    m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({grant_id, m0_cmd_ready, m1_cmd_ready, s_cmd_valid, busy} !== 5'b00011) begin
        errors++;
        $display("FAIL stall%0d got %b exp 00011", i, {grant_id, m0_cmd_ready, m1_cmd_ready, s_cmd_valid, busy});
      end
      cyc();
    end
    s_cmd_ready = 1;
    #1;
    checks++;
    if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10 || s_cmd_addr !== 32'h40) begin
      errors++;
      $display("FAIL stall_accept got %b a=%h exp 10 a=00000040", {m0_cmd_ready, m1_cmd_ready}, s_cmd_addr);
    end
    $display("txn m0 write 0x40 accepted after stall");
    cyc();
    m0_cmd_valid = 0;
    #1;
    checks++;
    if ({busy, grant_id} !== 2'b00) begin
      errors++;
      $display("FAIL stall_idle_hold got %b exp 00", {busy, grant_id});
    end
    cyc();
    checks++;
    if ({grant_id, m1_cmd_ready, m0_cmd_ready} !== 3'b110) begin
      errors++;
      $display("FAIL stall_next_m1 got %b exp 110", {grant_id, m1_cmd_ready, m0_cmd_ready});
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_withdraw();
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 1; s_cmd_ready = 1;
    cyc();
    cyc();
    m0_cmd_valid = 0; s_cmd_ready = 0; m1_cmd_valid = 1; m1_cmd_wr = 0;
    cyc();
    m1_cmd_valid = 0;
    #1;
    checks++;
    if ({grant_id, s_cmd_valid, m1_cmd_ready} !== 3'b100) begin
      errors++;
      $display("FAIL withdraw_cmd got %b exp 100", {grant_id, s_cmd_valid, m1_cmd_ready});
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_idle got busy=%b exp 0", busy);
    end
    m0_cmd_valid = 1; m1_cmd_valid = 1;
    cyc();
    checks++;
    if ({grant_id, f_grant_id} !== 2'b10) begin
      errors++;
      $display("FAIL withdraw_lastgrant got rr=%b fp=%b exp rr=1 fp=0", grant_id, f_grant_id);
    end
    $display("txn withdraw then arbitration grant=%0d", grant_id);
    clear_inputs();
    cyc();
  endtask

  task automatic test_spurious();
    do_reset();
    cyc();
    s_rsp_ready = 1; s_rsp_rdata = 32'h55;
    #1;
    checks++;
    if ({m0_rsp_ready, m1_rsp_ready, spurious_rsp} !== 3'b000) begin
      errors++;
      $display("FAIL spur_drop got %b exp 000", {m0_rsp_ready, m1_rsp_ready, spurious_rsp});
    end
    cyc();
    s_rsp_ready = 0;
    repeat (3) cyc();
    checks++;
    if ({spurious_rsp, f_spurious_rsp} !== 2'b11) begin
      errors++;
      $display("FAIL spur_sticky got %b exp 11", {spurious_rsp, f_spurious_rsp});
    end
    reset_ = 0;
    #1;
    checks++;
    if (spurious_rsp !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear got %b exp 0", spurious_rsp);
    end
    reset_ = 1;
    $display("txn spurious response in IDLE");
  endtask

  task automatic test_reset_rd_wait();
    do_reset();
    m0_cmd_valid = 1; m0_cmd_wr = 0; m0_cmd_addr = 32'h200; s_cmd_ready = 1;
    cyc();
    cyc();
    m0_cmd_valid = 0;
    m1_cmd_valid = 1; m1_cmd_wr = 0; m1_cmd_addr = 32'h300;
    s_rsp_ready = 1;
    reset_ = 0;
    #1;
    checks++;
    if ({busy, grant_id, s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready, spurious_rsp} !== 8'b0) begin
      errors++;
      $display("FAIL rdwait_reset got %b exp 00000000",
               {busy, grant_id, s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready, spurious_rsp});
    end
    s_rsp_ready = 0;
    cyc();
    reset_ = 1;
    cyc();
    checks++;
    if ({grant_id, s_cmd_valid, m1_cmd_ready} !== 3'b111 || s_cmd_addr !== 32'h300) begin
      errors++;
      $display("FAIL rdwait_m1_cmd got %b a=%h exp 111 a=00000300", {grant_id, s_cmd_valid, m1_cmd_ready}, s_cmd_addr);
    end
    cyc();
    m1_cmd_valid = 0;
    s_rsp_ready = 1; s_rsp_rdata = 32'h12345678;
    #1;
    checks++;
    if ({m1_rsp_ready, m0_rsp_ready} !== 2'b10 || m1_rsp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rdwait_m1_rsp got %b d=%h exp 10 d=12345678", {m1_rsp_ready, m0_rsp_ready}, m1_rsp_rdata);
    end
    cyc();
    s_rsp_ready = 0;
    checks++;
    if ({busy, spurious_rsp} !== 2'b00) begin
      errors++;
      $display("FAIL rdwait_done got %b exp 00", {busy, spurious_rsp});
    end
    $display("txn m1 read 0x300 after reset -> %h", m1_rsp_rdata);
    s_rsp_ready = 1;
    cyc();
    s_rsp_ready = 0;
    checks++;
    if (spurious_rsp !== 1'b1) begin
      errors++;
      $display("FAIL late_rsp got %b exp 1", spurious_rsp);
    end
  endtask

  initial begin
    clear_inputs();
    reset_ = 0;
    test_reset();
    test_read();
    test_round_robin();
    test_fixed_prio();
    test_stall();
    test_withdraw();
    test_spurious();
    test_reset_rd_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
